fifo_stream_reader: RTL

Read-side drain engine for the synchronous FIFO. It pulls words from the FIFO read port, which has a registered read with 1-cycle latency, and presents them downstream as a valid/ready stream. A 2-entry skid buffer gives full throughput (1 word/cycle) under continuous outReady, and no word is ever lost or duplicated under backpressure. It sits between the FIFO read port and any stream consumer.

---
 rtl/fifo_stream_reader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO into a valid/ready stream via a 2-entry skid buffer; FIFO_RD_CNT_EN adds a delivered-word counter.
// Latency: 2 clk from readEn to outValid (registered read, then registered buffer); 1 word/cycle steady state.
// Backpressure: readEn is credit-gated so at most 2 words (buffered + in flight) are held; outData is stable while stalled.
module fifo_stream_reader #(
  parameter int WIDTH    = 4,
  parameter int CNTWIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                empty,
  input  logic [WIDTH-1:0]    readData,
  output logic                readEn,
  input  logic                flush,
  output logic                outValid,
  input  logic                outReady,
  output logic [WIDTH-1:0]    outData
`ifdef FIFO_RD_CNT_EN
  ,
  output logic [CNTWIDTH-1:0] readCount
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              pending_q, pending_d;
  logic [WIDTH-1:0]  entry0_q, entry0_d;
  logic [WIDTH-1:0]  entry1_q, entry1_d;
  logic [1:0]        occ;
  logic [1:0]        credit;
  logic              push;
  logic              pop;

  if (WIDTH < 1 || CNTWIDTH < 1) begin : g_param_check
    $error("fifo_stream_reader: WIDTH and CNTWIDTH must be at least 1");
  end

  always_comb begin
    occ = 2'd0;
    case (state_q)
      S_ONE:   occ = 2'd1;
      S_TWO:   occ = 2'd2;
      default: occ = 2'd0;
    endcase
  end

  assign outValid = (state_q != S_EMPTY);
  assign outData  = entry0_q;
  assign push     = pending_q;
  assign pop      = outValid && outReady;

  // Words already owned (buffered or in flight) minus the one leaving this edge.
  assign credit = occ + {1'b0, push} - {1'b0, pop};
  assign readEn = !empty && !flush && !rst && (credit < 2'd2);

  always_comb begin
    state_d   = state_q;
    entry0_d  = entry0_q;
    entry1_d  = entry1_q;
    pending_d = readEn;
    if (flush) begin
      state_d   = S_EMPTY;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (push) begin
            state_d  = S_ONE;
            entry0_d = readData;
          end
        end
        S_ONE: begin
          if (push && !pop) begin
            state_d  = S_TWO;
            entry1_d = readData;
          end else if (pop && !push) begin
            state_d = S_EMPTY;
          end else if (push && pop) begin
            entry0_d = readData;
          end
        end
        S_TWO: begin
          if (pop) begin
            state_d  = S_ONE;
            entry0_d = entry1_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      pending_q <= 1'b0;
      entry0_q  <= '0;
      entry1_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      entry0_q  <= entry0_d;
      entry1_q  <= entry1_d;
    end
  end

`ifdef FIFO_RD_CNT_EN
  logic [CNTWIDTH-1:0] count_q, count_d;

  // Counts every accepted word, including one popped in a flush cycle.
  always_comb begin
    count_d = count_q;
    if (pop) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign readCount = count_q;
`endif

  // The credit gate must make a push into a full buffer impossible.
  assert property (@(posedge clk) disable iff (rst) !(state_q == S_TWO && push && !flush))
    else $error("fifo_stream_reader: push while skid buffer full");

endmodule
